// File: rtl/core_types_pkg.sv
// Shared types for the execute -> memory -> writeback path.
//   execute_signals_t : instruction record handed over by execute
//   mem_state_e       : memory-stage FSM states
//   lsu_size_e        : funct3 encodings of load/store sizes
//   wb_signals_t      : writeback record produced by the memory stage
//   lsu_width()       : maps funct3 to an access width; undefined codes map to word
package core_types_pkg;

  localparam logic [6:0] OP_LOAD = 7'b0000011;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] result;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
  } execute_signals_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mem_state_e;

  typedef enum logic [2:0] {
    LSU_LB  = 3'b000,
    LSU_LH  = 3'b001,
    LSU_LW  = 3'b010,
    LSU_LBU = 3'b100,
    LSU_LHU = 3'b101
  } lsu_size_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_signals_t;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } acc_width_e;

  // Stores only know SB/SH/SW; the unsigned load codes become word stores.
  function automatic acc_width_e lsu_width(input logic [2:0] funct3, input logic is_store);
    acc_width_e w;
    w = ACC_WORD;
    case (funct3)
      LSU_LB:  w = ACC_BYTE;
      LSU_LH:  w = ACC_HALF;
      LSU_LBU: w = is_store ? ACC_WORD : ACC_BYTE;
      LSU_LHU: w = is_store ? ACC_WORD : ACC_HALF;
      default: w = ACC_WORD;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering for the memory stage.
//   funct3, is_store, offset : access size/sign and byte offset within the word
//   store_data -> be, wdata  : byte enables and lane-replicated store data
//   rdata      -> load_data  : extracted and sign/zero-extended load result
// Misaligned offsets are truncated to the access size (half: offset&2'b10, word: 0).
module mem_lsu_align
  import core_types_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  acc_width_e  width;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    width = lsu_width(funct3, is_store);
    be    = 4'b1111;
    wdata = store_data;
    case (width)
      ACC_BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      ACC_HALF: begin
        be    = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    byte_lane = rdata[7:0];
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (funct3)
      LSU_LB:  load_data = {{24{byte_lane[7]}}, byte_lane};
      LSU_LBU: load_data = {24'b0, byte_lane};
      LSU_LH:  load_data = {{16{half_lane[15]}}, half_lane};
      LSU_LHU: load_data = {16'b0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: takes one execute record per handshake, runs loads and
// stores on a req/gnt/rvalid data memory, and emits one registered writeback
// record per retired instruction. Non-memory instructions retire next cycle.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   ex_i, ex_ready_o         : execute input and ready (ready only in IDLE)
//   flush_i                  : squash in-flight access, discard its writeback
//   dmem_req_o .. dmem_wdata_o : memory request channel
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i : memory grant/response
//   wb_*_o                   : writeback record (wb_valid_o is a 1-cycle pulse)
//   mem_err_o                : error pulse (timeout, or misalign when enabled)
// Build option: MEM_STAGE_MISALIGN_TRAP_EN traps misaligned half/word accesses
// instead of truncating the low address bits.
//
// state | meaning
// IDLE  | accepting; ALU ops retire next cycle
// REQ   | memory request held until granted
// WAIT  | granted, waiting for rvalid or timeout
// DRAIN | flushed after grant; swallow the response silently
module mem_stage
  import core_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  execute_signals_t ex_i,
  output logic             ex_ready_o,
  input  logic             flush_i,
  output logic             dmem_req_o,
  input  logic             dmem_gnt_i,
  output logic             dmem_we_o,
  output logic [31:0]      dmem_addr_o,
  output logic [3:0]       dmem_be_o,
  output logic [31:0]      dmem_wdata_o,
  input  logic             dmem_rvalid_i,
  input  logic [31:0]      dmem_rdata_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_rd_o,
  output logic             wb_we_o,
  output logic [31:0]      wb_data_o,
  output logic [31:0]      wb_pc_o,
  output logic             mem_err_o
);

  mem_state_e           state, state_d;
  logic [TIMEOUT_W-1:0] cnt, cnt_d;
  logic                 timeout;
  logic                 is_load, is_mem, latch;

  logic [31:0] req_addr, req_data, req_pc;
  logic [2:0]  req_funct3;
  logic        req_store, req_reg_write;
  logic [4:0]  req_rd;

  wb_signals_t wb, wb_d;
  logic        err, err_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;

  logic unused_inst_bits;
  assign unused_inst_bits = ^{ex_i.inst[31:15], ex_i.inst[11:7]};

  assign is_load = (ex_i.inst[6:0] == OP_LOAD);
  assign is_mem  = is_load | ex_i.mem_write;
  // Counter value sampled in the last WAIT/DRAIN cycle before giving up.
  assign timeout = (cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  acc_width_e ex_width;
  logic       misaligned;
  always_comb begin
    ex_width   = lsu_width(ex_i.inst[14:12], !is_load);
    misaligned = 1'b0;
    if (ex_width == ACC_HALF) misaligned = ex_i.mem_addr[0];
    if (ex_width == ACC_WORD) misaligned = (ex_i.mem_addr[1:0] != 2'b00);
  end
`endif

  mem_lsu_align u_align (
    .funct3     (req_funct3),
    .is_store   (req_store),
    .offset     (req_addr[1:0]),
    .store_data (req_data),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata      (dmem_rdata_i),
    .load_data  (load_data)
  );

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    latch   = 1'b0;
    wb_d    = '0;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (ex_i.valid && !flush_i) begin
          if (is_mem) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            if (misaligned) begin
              wb_d.valid = 1'b1;
              wb_d.rd    = ex_i.rd;
              wb_d.pc    = ex_i.pc;
              err_d      = 1'b1;
            end else begin
              latch   = 1'b1;
              state_d = REQ;
            end
`else
            latch   = 1'b1;
            state_d = REQ;
`endif
          end else begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = ex_i.rd;
            wb_d.pc        = ex_i.pc;
            wb_d.data      = ex_i.result;
            wb_d.reg_write = ex_i.reg_write && (ex_i.rd != 5'd0);
          end
        end
      end
      REQ: begin
        if (dmem_gnt_i) begin
          state_d = flush_i ? DRAIN : WAIT;
          cnt_d   = '0;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          state_d = IDLE;
          if (!flush_i) begin
            wb_d.valid     = 1'b1;
            wb_d.rd        = req_rd;
            wb_d.pc        = req_pc;
            wb_d.data      = req_store ? 32'd0 : load_data;
            wb_d.reg_write = !req_store && req_reg_write && (req_rd != 5'd0);
          end
        end else if (timeout) begin
          state_d = IDLE;
          if (!flush_i) begin
            wb_d.valid = 1'b1;
            wb_d.rd    = req_rd;
            wb_d.pc    = req_pc;
            err_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
          if (flush_i) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (dmem_rvalid_i || timeout) state_d = IDLE;
        else                          cnt_d   = cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      wb            <= '0;
      err           <= 1'b0;
      req_addr      <= '0;
      req_data      <= '0;
      req_pc        <= '0;
      req_funct3    <= '0;
      req_store     <= 1'b0;
      req_reg_write <= 1'b0;
      req_rd        <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wb    <= wb_d;
      err   <= err_d;
      if (latch) begin
        req_addr      <= ex_i.mem_addr;
        req_data      <= ex_i.mem_data;
        req_pc        <= ex_i.pc;
        req_funct3    <= ex_i.inst[14:12];
        req_store     <= !is_load;
        req_reg_write <= ex_i.reg_write;
        req_rd        <= ex_i.rd;
      end
    end
  end

  assign ex_ready_o   = (state == IDLE);
  // Request fields are held at zero outside REQ so the bus is quiet when idle.
  assign dmem_req_o   = (state == REQ);
  assign dmem_we_o    = dmem_req_o & req_store;
  assign dmem_addr_o  = dmem_req_o ? {req_addr[31:2], 2'b00} : 32'd0;
  assign dmem_be_o    = dmem_req_o ? lane_be : 4'd0;
  assign dmem_wdata_o = dmem_req_o ? lane_wdata : 32'd0;

  assign wb_valid_o = wb.valid;
  assign wb_rd_o    = wb.rd;
  assign wb_we_o    = wb.reg_write;
  assign wb_data_o  = wb.data;
  assign wb_pc_o    = wb.pc;
  assign mem_err_o  = err;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import core_types_pkg::*;

  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  execute_signals_t ex = '0;
  logic             ex_ready;
  logic             flush = 1'b0;
  logic             dmem_req, dmem_gnt = 1'b0, dmem_we;
  logic [31:0]      dmem_addr, dmem_wdata;
  logic [3:0]       dmem_be;
  logic             dmem_rvalid = 1'b0;
  logic [31:0]      dmem_rdata = '0;
  logic             wb_valid, wb_we, mem_err;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data, wb_pc;

  int errors = 0;
  int checks = 0;

  mem_stage #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ex_i(ex), .ex_ready_o(ex_ready), .flush_i(flush),
    .dmem_req_o(dmem_req), .dmem_gnt_i(dmem_gnt), .dmem_we_o(dmem_we),
    .dmem_addr_o(dmem_addr), .dmem_be_o(dmem_be), .dmem_wdata_o(dmem_wdata),
    .dmem_rvalid_i(dmem_rvalid), .dmem_rdata_i(dmem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_we_o(wb_we), .wb_data_o(wb_data),
    .wb_pc_o(wb_pc), .mem_err_o(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ex(input logic [6:0] opc, input logic [2:0] f3, input logic mw,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic rw, input logic [31:0] res, input logic [31:0] pc);
    ex.valid     = 1'b1;
    ex.inst      = {17'b0, f3, rd, opc};
    ex.mem_write = mw;
    ex.mem_addr  = addr;
    ex.mem_data  = data;
    ex.rd        = rd;
    ex.reg_write = rw;
    ex.result    = res;
    ex.pc        = pc;
  endtask

  // Accept a load, grant in the first REQ cycle, respond in the first WAIT cycle.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    set_ex(OP_LOAD, f3, 1'b0, addr, 32'd0, 5'd7, 1'b1, 32'd0, 32'h200);
    tick();
    ex.valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    tick();
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk1("rst_ready", ex_ready, 1'b1);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_err", mem_err, 1'b0);
    chk32("rst_be", {28'd0, dmem_be}, 32'd0);
    rst_n = 1'b1;

    // ALU ops back to back
    set_ex(OP_ALU, 3'b000, 1'b0, 32'd0, 32'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h100);
    tick();
    chk1("alu_wb_valid", wb_valid, 1'b1);
    chk32("alu_rd", {27'd0, wb_rd}, 32'd5);
    chk32("alu_data", wb_data, 32'hDEADBEEF);
    chk1("alu_we", wb_we, 1'b1);
    chk32("alu_pc", wb_pc, 32'h100);
    chk1("alu_ready", ex_ready, 1'b1);
    set_ex(OP_ALU, 3'b000, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'h00001234, 32'h104);
    tick();
    chk1("alu2_wb_valid", wb_valid, 1'b1);
    chk32("alu2_data", wb_data, 32'h00001234);
    chk1("alu2_we_rd0", wb_we, 1'b0);
    ex.valid = 1'b0;
    tick();
    chk1("alu_idle_wb", wb_valid, 1'b0);

    // SB to 0x1003, grant after two REQ cycles
    set_ex(OP_STORE, 3'b000, 1'b1, 32'h1003, 32'h000000A5, 5'd0, 1'b0, 32'd0, 32'h108);
    tick();
    ex.valid = 1'b0;
    chk1("sb_req", dmem_req, 1'b1);
    chk1("sb_we", dmem_we, 1'b1);
    chk32("sb_addr", dmem_addr, 32'h1000);
    chk32("sb_be", {28'd0, dmem_be}, 32'h8);
    chk32("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
    chk1("sb_ready", ex_ready, 1'b0);
    tick();
    chk1("sb_req_hold", dmem_req, 1'b1);
    chk32("sb_addr_hold", dmem_addr, 32'h1000);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    chk1("sb_req_after_gnt", dmem_req, 1'b0);
    chk1("sb_wait_wb", wb_valid, 1'b0);
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk1("sb_wb_valid", wb_valid, 1'b1);
    chk1("sb_wb_we", wb_we, 1'b0);
    chk32("sb_wb_pc", wb_pc, 32'h108);
    chk1("sb_ready_after", ex_ready, 1'b1);
    tick();
    chk1("sb_wb_pulse", wb_valid, 1'b0);

    // loads
    do_load(3'b000, 32'h2001, 32'h000080FF);
    chk1("lb_wb_valid", wb_valid, 1'b1);
    chk32("lb_data", wb_data, 32'hFFFFFF80);
    chk1("lb_we", wb_we, 1'b1);
    chk32("lb_rd", {27'd0, wb_rd}, 32'd7);
    do_load(3'b100, 32'h2001, 32'h000080FF);
    chk32("lbu_data", wb_data, 32'h00000080);
    do_load(3'b001, 32'h2002, 32'h80010000);
    chk32("lh_data", wb_data, 32'hFFFF8001);
    do_load(3'b101, 32'h2002, 32'h80010000);
    chk32("lhu_data", wb_data, 32'h00008001);
    do_load(3'b111, 32'h2000, 32'h11223344);
    chk32("undef_f3_lw_data", wb_data, 32'h11223344);

    // timeout: granted load with no response
    set_ex(OP_LOAD, 3'b010, 1'b0, 32'h2000, 32'd0, 5'd9, 1'b1, 32'd0, 32'h300);
    tick();
    ex.valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    tick();
    tick();
    tick();
    chk1("to_no_err_early", mem_err, 1'b0);
    chk1("to_ready_early", ex_ready, 1'b0);
    tick();
    chk1("to_err", mem_err, 1'b1);
    chk1("to_wb_valid", wb_valid, 1'b1);
    chk1("to_wb_we", wb_we, 1'b0);
    chk1("to_ready", ex_ready, 1'b1);
    tick();
    chk1("to_err_pulse", mem_err, 1'b0);

    // flush in WAIT, response arrives later
    set_ex(OP_LOAD, 3'b010, 1'b0, 32'h2000, 32'd0, 5'd9, 1'b1, 32'd0, 32'h304);
    tick();
    ex.valid = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fl_wait_wb", wb_valid, 1'b0);
    tick();
    chk1("fl_drain_ready", ex_ready, 1'b0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFEF00D;
    tick();
    dmem_rvalid = 1'b0;
    chk1("fl_drain_wb", wb_valid, 1'b0);
    chk1("fl_drain_err", mem_err, 1'b0);
    chk1("fl_idle", ex_ready, 1'b1);

    // SH to 0x1003 (truncated to upper half), then flush before grant
    set_ex(OP_STORE, 3'b001, 1'b1, 32'h1003, 32'h0000BEEF, 5'd0, 1'b0, 32'd0, 32'h308);
    tick();
    ex.valid = 1'b0;
    chk32("sh_be", {28'd0, dmem_be}, 32'hC);
    chk32("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk1("fl_req_dropped", dmem_req, 1'b0);
    chk1("fl_req_ready", ex_ready, 1'b1);
    chk1("fl_req_wb", wb_valid, 1'b0);

    // flush in IDLE drops an ALU op
    set_ex(OP_ALU, 3'b000, 1'b0, 32'd0, 32'd0, 5'd3, 1'b1, 32'h55, 32'h30C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex.valid = 1'b0;
    chk1("fl_idle_wb", wb_valid, 1'b0);

    // reset in REQ, then a stray response
    set_ex(OP_STORE, 3'b010, 1'b1, 32'h1000, 32'h1, 5'd0, 1'b0, 32'd0, 32'h310);
    tick();
    ex.valid = 1'b0;
    chk1("rq_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk1("rq_rst_req", dmem_req, 1'b0);
    chk1("rq_rst_ready", ex_ready, 1'b1);
    dmem_rvalid = 1'b1;
    tick();
    dmem_rvalid = 1'b0;
    chk1("rq_late_rvalid_wb", wb_valid, 1'b0);

    // misaligned LW at 0x3002
    set_ex(OP_LOAD, 3'b010, 1'b0, 32'h3002, 32'd0, 5'd4, 1'b1, 32'd0, 32'h400);
    tick();
    ex.valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    chk1("mis_req", dmem_req, 1'b0);
    chk1("mis_err", mem_err, 1'b1);
    chk1("mis_wb_valid", wb_valid, 1'b1);
    chk1("mis_wb_we", wb_we, 1'b0);
    chk1("mis_ready", ex_ready, 1'b1);
    tick();
    chk1("mis_req_after", dmem_req, 1'b0);
`else
    chk1("mis_req", dmem_req, 1'b1);
    chk32("mis_addr", dmem_addr, 32'h3000);
    chk32("mis_be", {28'd0, dmem_be}, 32'hF);
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h89ABCDEF;
    tick();
    dmem_rvalid = 1'b0;
    chk1("mis_wb_valid", wb_valid, 1'b1);
    chk32("mis_data", wb_data, 32'h89ABCDEF);
    chk1("mis_err", mem_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of execute.
- Consumes one execute_signals_t per handshake and performs loads and stores on a single-port data memory using a req/gnt/rvalid protocol.
- Byte-aligns store data and sign/zero-extends load data.
- Produces one registered writeback record per accepted instruction; non-memory instructions pass through with 1-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before the access is abandoned with an error.
- TIMEOUT_W, 8: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- ex_i  in  execute_signals_t  instruction from execute; ex_i.valid qualifies it.
- ex_ready_o  out  1  stage can accept; handshake = ex_i.valid & ex_ready_o.
- flush_i  in  1  squash in-flight access and discard its writeback.
- dmem_req_o  out  1  memory request.
- dmem_gnt_i  in  1  request accepted.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  32  lane-aligned store data.
- dmem_rvalid_i  in  1  response (load data or store ack).
- dmem_rdata_i  in  32  load data word.
- wb_valid_o  out  1  writeback record valid, single-cycle pulse.
- wb_rd_o  out  5  destination register.
- wb_we_o  out  1  register write enable (forced 0 when rd==0 or on error).
- wb_data_o  out  32  result or extended load data.
- wb_pc_o  out  32  PC of the retiring instruction.
- mem_err_o  out  1  pulse: timeout (or misalign, with feature).

Behaviour:
- Reset: FSM=IDLE; timeout counter=0; all outputs 0 except ex_ready_o=1. A reset mid-access abandons it; a late rvalid after reset is ignored.
- Opcode decode: load when ex_i.inst[6:0]==OP_LOAD; store when ex_i.mem_write; otherwise ALU.
- Size/sign: funct3 = ex_i.inst[14:12].
- ex_ready_o = (state==IDLE). Writeback cannot stall.
- ALU instruction in IDLE:
  - Next cycle: wb_valid_o=1, wb_data_o=ex_i.result, wb_rd_o/wb_pc_o from ex_i, wb_we_o=ex_i.reg_write & (rd!=0).
  - State stays IDLE, so throughput is 1 per cycle.
- Memory instruction in IDLE:
  - Latch the request; go to REQ.
  - Address source: ex_i.mem_addr. Store data source: ex_i.mem_data.
- Store lanes (off = addr[1:0]):
  - SB: be = 4'b0001<<off, wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<(off&2'b10), wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
- Load lanes:
  - Byte extracted at off; half extracted at off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Undefined funct3 values are treated as LW/SW.
- REQ:
  - dmem_req_o=1 with stable addr/be/we/wdata until dmem_gnt_i.
  - On gnt, go to WAIT and clear the counter.
  - gnt in the same cycle as entry to REQ is legal.
- WAIT:
  - Counter increments each cycle.
  - On dmem_rvalid_i: next cycle wb_valid_o=1.
    - Load: wb_data_o = extended data; wb_we_o=reg_write & (rd!=0).
    - Store: wb_we_o=0.
  - Return to IDLE.
  - rvalid in the same cycle as gnt is not legal per protocol; rvalid is ignored in REQ.
- Timeout: counter reaches TIMEOUT_CYCLES with no rvalid -> mem_err_o=1 and wb_valid_o=1 with wb_we_o=0 next cycle; go to IDLE.
- Flush:
  - In IDLE: the accepted instruction is dropped, with no wb.
  - In REQ before gnt: drop the request and go to IDLE the next cycle.
  - In WAIT: go to DRAIN.
  - DRAIN: wait for rvalid or timeout, suppress wb_valid_o and mem_err_o, then IDLE.
  - Simultaneous flush and gnt in REQ -> DRAIN.
  - Simultaneous flush and rvalid in WAIT -> result discarded, IDLE.
- FSM states: IDLE, REQ, WAIT, DRAIN.

Optional Feature:
- Macro: MEM_STAGE_MISALIGN_TRAP_EN.
- Defined: a misaligned access (LH/LHU/SH with off[0]=1; LW/SW with off!=0) makes no memory request. Next cycle: mem_err_o=1, wb_valid_o=1, wb_we_o=0; state stays IDLE.
- Undefined: low address bits are silently truncated to the access size (half uses off&2'b10, word uses off=0) and the access proceeds.

Decomposition:
- core_types_pkg additions:
  - mem_state_e {IDLE, REQ, WAIT, DRAIN}.
  - lsu_size_e (funct3 encodings LB=000, LH=001, LW=010, LBU=100, LHU=101).
  - wb_signals_t {valid, rd, reg_write, data, pc}.
- One combinational sub-module, mem_lsu_align: store be/wdata generation and load extract/extension from funct3 and addr[1:0].

Test Plan:
- ALU op with rd=5, result=0xDEADBEEF, reg_write=1 -> next cycle wb_valid_o=1, wb_rd_o=5, wb_data_o=0xDEADBEEF, wb_we_o=1; back-to-back ops retire 1 per cycle.
- SB of data=0x000000A5 to addr 0x1003, gnt after 2 cycles -> dmem_addr_o=0x1000, be=4'b1000, wdata=0xA5A5A5A5; wb_valid_o=1 with wb_we_o=0 the cycle after rvalid.
- LB from addr 0x2001 with rdata=0x0000_80FF -> wb_data_o=0xFFFFFF80; LBU gives 0x00000080; LH at 0x2002 with rdata=0x8001_0000 -> wb_data_o=0xFFFF8001.
- TIMEOUT_CYCLES=4, load granted, rvalid never arrives -> mem_err_o pulse 4 cycles after gnt, wb_we_o=0, ex_ready_o=1 afterwards.
- Flush asserted in WAIT, rvalid 3 cycles later -> no wb_valid_o, no mem_err_o, IDLE after rvalid; rst_ni=0 in REQ -> dmem_req_o=0 the next cycle.
- With MEM_STAGE_MISALIGN_TRAP_EN: LW at 0x3002 -> dmem_req_o never asserted, mem_err_o=1 and wb_valid_o=1 next cycle. Without it: access goes to 0x3000 with be=4'b1111.
